priority_arb_rr: RTL

- Parametrised, registered N-requester arbiter; next generation of the team's 4-bit combinational priority selector.
- Supports two runtime modes: fixed priority (MSB highest) and round-robin.
- Holds (locks) a grant while the winning request stays asserted.
- Sits between multiple requesters and one shared resource (bus, port, functional unit).

---
 rtl/arb_pkg.sv | 9 +
 rtl/arb_winner.sv | 45 ++++
 rtl/priority_arb_rr.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared state and mode encodings for the priority_arb_rr arbiter family.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/arb_winner.sv
// Combinational winner search over an N-bit request vector, fixed-priority or round-robin.
// Reusable by any arbiter that keeps its own last-winner index.
module arb_winner
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] last_idx,
    input  logic                 mode,
    output logic                 found,
    output logic [$clog2(N)-1:0] win_idx
);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0] cand;
    int           start;
    int           pos;

    assign cand = req & ~mask;

    // Search order is start-1, start-2, ... wrapping to start; fixed mode is the
    // same walk anchored at 0, which gives MSB-first priority.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the block can infer a latch.
        found   = 1'b0;
        win_idx = '0;
        start   = (mode == ARB_MODE_RR) ? int'(last_idx) : 0;
        pos     = 0;
        // Walk from lowest priority to highest so the final hit is the winner.
        for (int k = N; k >= 1; k--) begin
            pos = start - k;
            if (pos < 0) begin
                pos = pos + N;
            end
            if (cand[IDX_W'(pos)]) begin
                found   = 1'b1;
                win_idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/priority_arb_rr.sv
// Registered N-requester arbiter (fixed priority or round-robin) with grant locking.
// Define ARB_BURST_LIMIT_EN to force release after MAX_BURST cycles when others are waiting.
module priority_arb_rr
    import arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    if (N < 2 || MAX_BURST < 1) begin : g_param_check
        $error("priority_arb_rr: N must be >= 2 and MAX_BURST >= 1");
    end

    arb_state_t       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             burst_hit;
    logic             release_grant;

    // The current grant is the mask: harmless when its request has dropped, and
    // exactly the exclusion needed on a burst-limit release.
    arb_winner #(.N(N)) u_winner (
        .req      (req),
        .mask     (gnt_q),
        .last_idx (last_idx_q),
        .mode     (mode),
        .found    (win_found),
        .win_idx  (win_idx)
    );

`ifdef ARB_BURST_LIMIT_EN
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] burst_q, burst_d;

    assign burst_hit = (burst_q == BURST_MAX) && |(req & ~gnt_q);

    always_comb begin
        burst_d = burst_q;
        if (state_d == ARB_IDLE) begin
            burst_d = '0;
        end else if (state_q == ARB_IDLE || release_grant) begin
            burst_d = CNT_W'(1);
        end else if (burst_q != BURST_MAX) begin
            burst_d = burst_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign burst_hit = 1'b0;
`endif

    assign release_grant = !req[gnt_idx_q] || burst_hit;

    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        last_idx_d  = last_idx_q;
        if (!en) begin
            state_d     = ARB_IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_idx_d   = '0;
        end else if (state_q == ARB_IDLE || release_grant) begin
            if (win_found) begin
                state_d     = ARB_GRANT;
                gnt_d       = N'(1) << win_idx;
                gnt_valid_d = 1'b1;
                gnt_idx_d   = win_idx;
                last_idx_d  = win_idx;
            end else begin
                state_d     = ARB_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            last_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule
